// File: rtl/usb_pktbuf_arbiter.sv
`default_nettype none
// ============================================================================
// Module : usb_pktbuf_arbiter
// Desc   : SIE/CPU arbiter for the single-port USB packet buffer RAM.
// Rev    : 1.0 - initial release
// ============================================================================
module usb_pktbuf_arbiter #(
   parameter int AW         = 7,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sie_req,
   input  logic          sie_we,
   input  logic [AW-1:0] sie_addr,
   input  logic [7:0]    sie_wdata,
   output logic          sie_gnt,
   output logic          sie_rvalid,
   output logic [7:0]    sie_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [7:0]    cpu_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata,
   output logic [7:0]    force_cnt
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_SIE  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_e;

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_FORCE  = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [7:0]    force_cnt_q, force_cnt_d;
   owner_e        tag1_q, tag1_d, tag2_q;
   logic          mem_en_q, mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [7:0]    mem_wdata_q;
   logic [7:0]    sie_rdata_q, cpu_rdata_q;
   logic          gnt_sie, gnt_cpu;

   // FORCE is entered exactly when the denied-streak counter hits STARVE_MAX,
   // so it doubles as the "counter saturated" flag for arbitration.
   always_comb begin
      gnt_sie     = 1'b0;
      gnt_cpu     = 1'b0;
      state_d     = state_q;
      starve_d    = starve_q;
      force_cnt_d = force_cnt_q;
      tag1_d      = OWN_NONE;

      if (state_q == ST_FORCE && cpu_req) begin
         gnt_cpu = 1'b1;
      end else if (sie_req) begin
         gnt_sie = 1'b1;
      end else if (cpu_req) begin
         gnt_cpu = 1'b1;
      end

      if (!cpu_req || gnt_cpu) begin
         starve_d = '0;
      end else if (starve_q != C_STARVE_MAX) begin
         starve_d = starve_q + 1'b1;
      end

      if (state_q == ST_FORCE && gnt_cpu && sie_req && force_cnt_q != 8'hFF) begin
         force_cnt_d = force_cnt_q + 8'd1;
      end

      case (state_q)
         ST_NORMAL: if (starve_d == C_STARVE_MAX) state_d = ST_FORCE;
         ST_FORCE:  if (gnt_cpu || !cpu_req)      state_d = ST_NORMAL;
         default:   state_d = ST_NORMAL;
      endcase

      if (gnt_sie && !sie_we) begin
         tag1_d = OWN_SIE;
      end else if (gnt_cpu && !cpu_we) begin
         tag1_d = OWN_CPU;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_NORMAL;
         starve_q    <= '0;
         force_cnt_q <= 8'd0;
         tag1_q      <= OWN_NONE;
         tag2_q      <= OWN_NONE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'd0;
         sie_rdata_q <= 8'd0;
         cpu_rdata_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         force_cnt_q <= force_cnt_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag1_q;
         mem_en_q    <= gnt_sie | gnt_cpu;
         mem_we_q    <= 1'b0;
         if (gnt_sie) begin
            mem_we_q    <= sie_we;
            mem_addr_q  <= sie_addr;
            mem_wdata_q <= sie_wdata;
         end else if (gnt_cpu) begin
            mem_we_q    <= cpu_we;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
         end
         if (tag2_q == OWN_SIE) sie_rdata_q <= mem_rdata;
         if (tag2_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
      end
   end

   // Read data is forwarded straight from the RAM in the valid cycle, then held.
   assign sie_gnt    = gnt_sie;
   assign cpu_gnt    = gnt_cpu;
   assign sie_rvalid = (tag2_q == OWN_SIE);
   assign cpu_rvalid = (tag2_q == OWN_CPU);
   assign sie_rdata  = sie_rvalid ? mem_rdata : sie_rdata_q;
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign force_cnt  = force_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_pktbuf_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_usb_pktbuf_arbiter
// Desc   : Self-checking bench for usb_pktbuf_arbiter with a behavioural RAM.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_usb_pktbuf_arbiter;
   localparam int AW         = 7;
   localparam int STARVE_MAX = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          sie_req, sie_we, cpu_req, cpu_we;
   logic [AW-1:0] sie_addr, cpu_addr;
   logic [7:0]    sie_wdata, cpu_wdata;
   logic          sie_gnt, sie_rvalid, cpu_gnt, cpu_rvalid;
   logic [7:0]    sie_rdata, cpu_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata, mem_rdata, force_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] ram [0:127];
   logic [7:0] ram_rdata;
   logic       preload;

   typedef struct {
      int         due;
      bit         to_sie;
      logic [7:0] data;
   } rd_t;

   always #5 clk = ~clk;

   usb_pktbuf_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .sie_req(sie_req), .sie_we(sie_we), .sie_addr(sie_addr), .sie_wdata(sie_wdata),
      .sie_gnt(sie_gnt), .sie_rvalid(sie_rvalid), .sie_rdata(sie_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .force_cnt(force_cnt)
   );

   function automatic logic [7:0] init_val(input int i);
      case (i)
         'h01:    return 8'h11;
         'h02:    return 8'h22;
         'h10:    return 8'hA5;
         default: return 8'(i * 7 + 3);
      endcase
   endfunction

   // Single-port synchronous RAM: read data appears the cycle after mem_en.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        ram_rdata     <= ram[mem_addr];
      end
   end
   assign mem_rdata = ram_rdata;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sie_req = 1'b0; sie_we = 1'b0; sie_addr = '0; sie_wdata = 8'd0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'd0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
      n_checks++; if (force_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_force_cnt: got %h want 00", force_cnt); end
      n_checks++; if ({sie_rvalid, cpu_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {sie_rvalid, cpu_rvalid}); end
      n_checks++; if ({sie_rdata, cpu_rdata} !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", {sie_rdata, cpu_rdata}); end
      n_checks++; if (mem_addr !== 7'h00) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_sie_read();
      next_cycle();
      sie_req = 1'b1; sie_we = 1'b0; sie_addr = 7'h10;
      @(negedge clk);
      n_checks++; if ({sie_gnt, cpu_gnt} !== 2'b10) begin n_fail++; $display("FAIL sie_read_gnt: got %b want 10", {sie_gnt, cpu_gnt}); end
      next_cycle();
      sie_req = 1'b0;
      @(negedge clk);
      n_checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 7'h10}) begin n_fail++; $display("FAIL sie_read_mem: got en=%b we=%b addr=%h want en=1 we=0 addr=10", mem_en, mem_we, mem_addr); end
      next_cycle();
      @(negedge clk);
      n_checks++; if ({sie_rvalid, cpu_rvalid, sie_rdata} !== {2'b10, 8'hA5}) begin n_fail++; $display("FAIL sie_read_data: got sv=%b cv=%b d=%h want sv=1 cv=0 d=a5", sie_rvalid, cpu_rvalid, sie_rdata); end
      next_cycle();
      @(negedge clk);
      n_checks++; if ({sie_rvalid, sie_rdata} !== {1'b0, 8'hA5}) begin n_fail++; $display("FAIL sie_read_hold: got sv=%b d=%h want sv=0 d=a5", sie_rvalid, sie_rdata); end
   endtask

   task automatic test_priority();
      next_cycle();
      sie_req = 1'b1; sie_we = 1'b0; sie_addr = 7'h05;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h02;
      @(negedge clk);
      n_checks++; if ({sie_gnt, cpu_gnt} !== 2'b10) begin n_fail++; $display("FAIL prio_both: got %b want 10", {sie_gnt, cpu_gnt}); end
      next_cycle();
      sie_req = 1'b0;
      @(negedge clk);
      n_checks++; if ({sie_gnt, cpu_gnt} !== 2'b01) begin n_fail++; $display("FAIL prio_cpu_next: got %b want 01", {sie_gnt, cpu_gnt}); end
      next_cycle();
      cpu_req = 1'b0;
      @(negedge clk);
      n_checks++; if ({sie_rvalid, cpu_rvalid, sie_rdata} !== {2'b10, init_val(5)}) begin n_fail++; $display("FAIL prio_sie_rd: got sv=%b cv=%b d=%h want sv=1 cv=0 d=%h", sie_rvalid, cpu_rvalid, sie_rdata, init_val(5)); end
      next_cycle();
      @(negedge clk);
      n_checks++; if ({sie_rvalid, cpu_rvalid, cpu_rdata} !== {2'b01, 8'h22}) begin n_fail++; $display("FAIL prio_cpu_rd: got sv=%b cv=%b d=%h want sv=0 cv=1 d=22", sie_rvalid, cpu_rvalid, cpu_rdata); end
   endtask

   task automatic test_starvation();
      for (int c = 0; c < 9; c++) begin
         next_cycle();
         sie_req = 1'b1; sie_we = 1'b0; sie_addr = 7'h01;
         cpu_req = (c <= 4); cpu_we = 1'b0; cpu_addr = 7'h02;
         @(negedge clk);
         n_checks++;
         if ({sie_gnt, cpu_gnt} !== ((c == 4) ? 2'b01 : 2'b10)) begin
            n_fail++; $display("FAIL starve_gnt c=%0d: got %b want %b", c, {sie_gnt, cpu_gnt}, (c == 4) ? 2'b01 : 2'b10);
         end
         if (c == 0 || c == 5) begin
            n_checks++;
            if (force_cnt !== ((c == 5) ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL starve_force_cnt c=%0d: got %0d want %0d", c, force_cnt, (c == 5) ? 1 : 0); end
         end
      end
      idle();
      repeat (3) next_cycle();
   endtask

   task automatic test_alternate();
      for (int c = 0; c < 12; c++) begin
         next_cycle();
         sie_req = (c < 8) && (c % 2 == 0); sie_we = 1'b0; sie_addr = 7'h01;
         cpu_req = (c < 8) && (c % 2 == 1); cpu_we = 1'b0; cpu_addr = 7'h02;
         @(negedge clk);
         if (c >= 2 && c < 10) begin
            n_checks++;
            if ((c % 2 == 0) ? ({sie_rvalid, cpu_rvalid, sie_rdata} !== {2'b10, 8'h11})
                             : ({sie_rvalid, cpu_rvalid, cpu_rdata} !== {2'b01, 8'h22})) begin
               n_fail++; $display("FAIL alt_rd c=%0d: got sv=%b cv=%b sd=%h cd=%h", c, sie_rvalid, cpu_rvalid, sie_rdata, cpu_rdata);
            end
         end
      end
      idle();
   endtask

   task automatic test_write_read();
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h7F; cpu_wdata = 8'h3C;
      @(negedge clk);
      n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b want 1", cpu_gnt); end
      next_cycle();
      cpu_req = 1'b0; sie_req = 1'b1; sie_we = 1'b0; sie_addr = 7'h7F;
      @(negedge clk);
      n_checks++; if ({sie_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 7'h7F, 8'h3C}) begin
         n_fail++; $display("FAIL wr_mem: got g=%b en=%b we=%b a=%h d=%h want g=1 en=1 we=1 a=7f d=3c", sie_gnt, mem_en, mem_we, mem_addr, mem_wdata);
      end
      next_cycle();
      sie_req = 1'b0;
      @(negedge clk);
      n_checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 7'h7F}) begin n_fail++; $display("FAIL rd_mem: got en=%b we=%b a=%h want en=1 we=0 a=7f", mem_en, mem_we, mem_addr); end
      next_cycle();
      @(negedge clk);
      n_checks++; if ({sie_rvalid, cpu_rvalid, sie_rdata} !== {2'b10, 8'h3C}) begin n_fail++; $display("FAIL wr_rd_data: got sv=%b cv=%b d=%h want sv=1 cv=0 d=3c", sie_rvalid, cpu_rvalid, sie_rdata); end
   endtask

   task automatic test_reset_midread();
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h02;
      @(negedge clk);
      n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rmr_gnt: got %b want 1", cpu_gnt); end
      next_cycle();
      cpu_req = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++; if ({mem_en, force_cnt} !== 9'd0) begin n_fail++; $display("FAIL rmr_async: got en=%b fc=%0d want en=0 fc=0", mem_en, force_cnt); end
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_no_rvalid c=%0d: got %b want 0", c, cpu_rvalid); end
         next_cycle();
      end
      sie_req = 1'b1; sie_we = 1'b0; sie_addr = 7'h10;
      next_cycle();
      sie_req = 1'b0;
      next_cycle();
      @(negedge clk);
      n_checks++; if ({sie_rvalid, sie_rdata} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL rmr_resume: got sv=%b d=%h want sv=1 d=a5", sie_rvalid, sie_rdata); end
   endtask

   task automatic test_force_saturate();
      for (int c = 0; c <= 1300; c++) begin
         next_cycle();
         sie_req = 1'b1; sie_we = 1'b0; sie_addr = 7'h03;
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h04;
         @(negedge clk);
         if (c == 500 || c == 1300) begin
            n_checks++;
            if (force_cnt !== ((c == 500) ? 8'd100 : 8'd255)) begin
               n_fail++; $display("FAIL force_sat c=%0d: got %0d want %0d", c, force_cnt, (c == 500) ? 100 : 255);
            end
         end
      end
      idle();
      repeat (3) next_cycle();
   endtask

   task automatic test_random();
      logic [7:0]    model_mem [0:127];
      rd_t           pend [$];
      rd_t           r;
      int            streak, fcnt;
      logic [AW-1:0] last_addr, a;
      logic [7:0]    last_wdata, last_sie, last_cpu, d;
      logic          p_en, p_we, e_force, e_sg, e_cg, e_sv, e_cv, we;

      idle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < 128; i++) model_mem[i] = ram[i];
      streak = 0; fcnt = 0; last_addr = '0; last_wdata = 8'd0;
      last_sie = 8'd0; last_cpu = 8'd0; p_en = 1'b0; p_we = 1'b0;

      for (int k = 0; k < 400; k++) begin
         next_cycle();
         sie_req   = ($urandom_range(0, 99) < 80);
         sie_we    = 1'($urandom_range(0, 1));
         sie_addr  = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 15));
         sie_wdata = 8'($urandom);
         cpu_req   = ($urandom_range(0, 99) < 60);
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_addr  = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 15));
         cpu_wdata = 8'($urandom);
         @(negedge clk);

         e_force = (streak == STARVE_MAX) && cpu_req;
         e_sg    = !e_force && sie_req;
         e_cg    = e_force || (!sie_req && cpu_req);
         e_sv = 1'b0; e_cv = 1'b0;
         if (pend.size() > 0 && pend[0].due == k) begin
            r = pend.pop_front();
            if (r.to_sie) begin e_sv = 1'b1; last_sie = r.data; end
            else          begin e_cv = 1'b1; last_cpu = r.data; end
         end

         n_checks++; if ({sie_gnt, cpu_gnt} !== {e_sg, e_cg}) begin n_fail++; $display("FAIL rnd_gnt k=%0d: got %b want %b", k, {sie_gnt, cpu_gnt}, {e_sg, e_cg}); end
         n_checks++; if (force_cnt !== 8'(fcnt)) begin n_fail++; $display("FAIL rnd_force_cnt k=%0d: got %0d want %0d", k, force_cnt, fcnt); end
         n_checks++; if ({mem_en, mem_addr, mem_wdata} !== {p_en, last_addr, last_wdata}) begin
            n_fail++; $display("FAIL rnd_mem k=%0d: got en=%b a=%h d=%h want en=%b a=%h d=%h", k, mem_en, mem_addr, mem_wdata, p_en, last_addr, last_wdata);
         end
         if (p_en) begin
            n_checks++; if (mem_we !== p_we) begin n_fail++; $display("FAIL rnd_mem_we k=%0d: got %b want %b", k, mem_we, p_we); end
         end
         n_checks++; if ({sie_rvalid, cpu_rvalid, sie_rdata, cpu_rdata} !== {e_sv, e_cv, last_sie, last_cpu}) begin
            n_fail++; $display("FAIL rnd_rd k=%0d: got sv=%b cv=%b sd=%h cd=%h want sv=%b cv=%b sd=%h cd=%h", k, sie_rvalid, cpu_rvalid, sie_rdata, cpu_rdata, e_sv, e_cv, last_sie, last_cpu);
         end

         if (e_sg || e_cg) begin
            we = e_sg ? sie_we : cpu_we;
            a  = e_sg ? sie_addr : cpu_addr;
            d  = e_sg ? sie_wdata : cpu_wdata;
            last_addr = a; last_wdata = d; p_we = we;
            if (we) model_mem[a] = d;
            else    pend.push_back('{due: k + 2, to_sie: e_sg, data: model_mem[a]});
         end
         p_en = e_sg || e_cg;
         if (e_force && sie_req && fcnt < 255) fcnt++;
         if (cpu_req && !e_cg) streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
         else                  streak = 0;
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      preload = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1 preload = 1'b0;
      test_reset();
      test_sie_read();
      test_priority();
      test_starvation();
      test_alternate();
      test_write_read();
      test_reset_midread();
      test_force_saturate();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
